// File: rtl/div_issue_ctrl_pkg.sv
// Shared definitions for the divide issue controller: sequencing states,
// the default divider settle time and the divisor range check.
package div_issue_ctrl_pkg;

  localparam int DIV_LATENCY_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // The divider only sees op_b[15:0]; anything that does not fit a signed
  // 16-bit value must be reported as an exception instead.
  function automatic logic divisor_out_of_range(input logic [31:0] b);
    return b[31:16] != {16{b[15]}};
  endfunction

endpackage

// File: rtl/div_issue_ctrl.sv
// Issue/stall/writeback sequencer wrapped around an external combinational
// divider that is given DIV_LATENCY cycles to settle.
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int DIV_LATENCY = DIV_LATENCY_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_start,
  input  logic        flush,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  dest_reg,
  output logic [31:0] div_operandA,
  output logic [15:0] div_operandB,
  output logic        div_ctrl_DIV,
  input  logic [31:0] div_result,
  input  logic        div_exception,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_reg,
  output logic        wb_exception
);

  localparam logic [3:0] CNT_LOAD = 4'(DIV_LATENCY - 1);

  div_state_e state, state_next;
  logic [3:0] cnt;
  logic [4:0] dest_q;
  logic       range_q;
  logic       accept;
  logic       capture;
  logic       finish;
  logic       result_exc;

  assign accept     = ctrl_start & ~flush;
  assign result_exc = div_exception | range_q;

  always_comb begin
    state_next   = state;
    stall        = 1'b0;
    div_ctrl_DIV = 1'b0;
    capture      = 1'b0;
    finish       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stall      = 1'b1;
          capture    = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        stall        = 1'b1;
        div_ctrl_DIV = 1'b1;
        if (flush) begin
          state_next = IDLE;
        end else if (cnt == 4'd0) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        // A start presented alongside the writeback is taken immediately.
        if (accept) begin
          stall      = 1'b1;
          capture    = 1'b1;
          state_next = WAIT;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt          <= 4'd0;
      div_operandA <= 32'd0;
      div_operandB <= 16'd0;
      dest_q       <= 5'd0;
      range_q      <= 1'b0;
      wb_valid     <= 1'b0;
      wb_data      <= 32'd0;
      wb_reg       <= 5'd0;
      wb_exception <= 1'b0;
    end else begin
      wb_valid <= finish;
      if (capture) begin
        div_operandA <= op_a;
        div_operandB <= op_b[15:0];
        dest_q       <= dest_reg;
        range_q      <= divisor_out_of_range(op_b);
        cnt          <= CNT_LOAD;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (finish) begin
        wb_exception <= result_exc;
        wb_data      <= result_exc ? 32'd0 : div_result;
        wb_reg       <= dest_q;
      end
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Randomized self-checking bench for div_issue_ctrl, with a behavioural
// divider beside the DUT and a transaction-level reference model.
module tb_div_issue_ctrl;

  localparam int L = 4;

  logic        clock;
  logic        reset;
  logic        ctrl_start;
  logic        flush;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  dest_reg;
  logic [31:0] div_operandA;
  logic [15:0] div_operandB;
  logic        div_ctrl_DIV;
  logic [31:0] div_result;
  logic        div_exception;
  logic        stall;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_reg;
  logic        wb_exception;
  logic [31:0] div_bsx;

  int tests_run;
  int tests_failed;
  bit chained;

  div_issue_ctrl #(.DIV_LATENCY(L)) dut (
    .clock(clock),
    .reset(reset),
    .ctrl_start(ctrl_start),
    .flush(flush),
    .op_a(op_a),
    .op_b(op_b),
    .dest_reg(dest_reg),
    .div_operandA(div_operandA),
    .div_operandB(div_operandB),
    .div_ctrl_DIV(div_ctrl_DIV),
    .div_result(div_result),
    .div_exception(div_exception),
    .stall(stall),
    .wb_valid(wb_valid),
    .wb_data(wb_data),
    .wb_reg(wb_reg),
    .wb_exception(wb_exception)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Stand-in for the external divider: garbage quotient on divide-by-zero.
  always_comb begin
    div_bsx       = {{16{div_operandB[15]}}, div_operandB};
    div_exception = (div_operandB == 16'd0);
    if (div_exception)
      div_result = 32'hDEAD_BEEF;
    else if (div_operandA == 32'h8000_0000 && div_bsx == 32'hFFFF_FFFF)
      div_result = div_operandA;
    else
      div_result = $signed(div_operandA) / $signed(div_bsx);
  end

  // Reference: {exception, quotient} from the full 32-bit operands.
  function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb < -32768 || sb > 32767 || sb == 0) return {1'b1, 32'h0};
    q = sa / sb;
    return {1'b0, q[31:0]};
  endfunction

  function automatic logic [31:0] rand_b();
    logic [15:0] s;
    case ($urandom_range(0, 3))
      0: begin
        s = 16'($urandom);
        return {{16{s[15]}}, s};
      end
      1: return 32'd0;
      2: return $urandom;
      default: begin
        s = 16'($urandom_range(1, 20));
        return ($urandom_range(0, 1) == 1) ? -{16'd0, s} : {16'd0, s};
      end
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic fl, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] tag);
    ctrl_start = start;
    flush      = fl;
    op_a       = a;
    op_b       = b;
    dest_reg   = tag;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Cycle 0 is the start cycle (skipped when it overlapped the previous DONE).
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag,
                         input int flush_at, input bit chain_next, input logic [31:0] na,
                         input logic [31:0] nb, input logic [4:0] ntag);
    logic [32:0] exp;
    logic        fl;
    exp = ref_div(a, b);
    if (!chained) begin
      applyStimulus(1'b1, 1'b0, a, b, tag);
      @(negedge clock);
      checkOutput("start_stall", 32'(stall), 32'd1);
      checkOutput("start_wb_valid", 32'(wb_valid), 32'd0);
      next_cycle();
    end
    for (int k = 1; k <= L; k++) begin
      applyStimulus(1'($urandom_range(0, 1)), (k == flush_at), $urandom, $urandom, 5'($urandom));
      @(negedge clock);
      checkOutput("wait_stall", 32'(stall), 32'd1);
      checkOutput("wait_div", 32'(div_ctrl_DIV), 32'd1);
      checkOutput("wait_opA", div_operandA, a);
      checkOutput("wait_opB", 32'(div_operandB), 32'(b[15:0]));
      checkOutput("wait_wb_valid", 32'(wb_valid), 32'd0);
      next_cycle();
      if (k == flush_at) break;
    end
    if (flush_at >= 1 && flush_at <= L) begin
      for (int k = 0; k < 2; k++) begin
        applyStimulus(1'b0, 1'b0, a, b, tag);
        @(negedge clock);
        checkOutput("flushed_stall", 32'(stall), 32'd0);
        checkOutput("flushed_div", 32'(div_ctrl_DIV), 32'd0);
        checkOutput("flushed_wb_valid", 32'(wb_valid), 32'd0);
        next_cycle();
      end
      chained = 1'b0;
      return;
    end
    if (chain_next) begin
      applyStimulus(1'b1, 1'b0, na, nb, ntag);
    end else begin
      fl = 1'($urandom_range(0, 1));
      applyStimulus(fl & 1'($urandom_range(0, 1)), fl, $urandom, $urandom, 5'($urandom));
    end
    @(negedge clock);
    checkOutput("done_wb_valid", 32'(wb_valid), 32'd1);
    checkOutput("done_wb_data", wb_data, exp[31:0]);
    checkOutput("done_wb_reg", 32'(wb_reg), 32'(tag));
    checkOutput("done_wb_exc", 32'(wb_exception), 32'(exp[32]));
    checkOutput("done_div", 32'(div_ctrl_DIV), 32'd0);
    checkOutput("done_stall", 32'(stall), 32'(chain_next));
    next_cycle();
    chained = chain_next;
    if (!chain_next) begin
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
      @(negedge clock);
      checkOutput("after_wb_valid", 32'(wb_valid), 32'd0);
      checkOutput("after_stall", 32'(stall), 32'd0);
      next_cycle();
    end
  endtask

  initial begin
    logic [31:0] cur_a, cur_b, nxt_a, nxt_b;
    logic [4:0]  cur_tag, nxt_tag;
    int          flush_at;
    bit          chain;

    tests_run    = 0;
    tests_failed = 0;
    chained      = 1'b0;
    reset        = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    #12;
    checkOutput("reset_opA", div_operandA, 32'd0);
    checkOutput("reset_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("reset_wb_data", wb_data, 32'd0);
    checkOutput("reset_stall", 32'(stall), 32'd0);
    checkOutput("reset_div", 32'(div_ctrl_DIV), 32'd0);
    next_cycle();
    reset = 1'b0;
    next_cycle();

    run_div(32'd100, 32'd7, 5'd5, 0, 1'b0, 32'd0, 32'd0, 5'd0);
    run_div(-32'sd100, 32'd7, 5'd9, 0, 1'b0, 32'd0, 32'd0, 5'd0);
    run_div(32'd55, 32'd0, 5'd3, 0, 1'b0, 32'd0, 32'd0, 5'd0);
    run_div(32'd55, 32'h0001_0000, 5'd4, 0, 1'b0, 32'd0, 32'd0, 5'd0);
    run_div(32'd55, 32'h0001_0007, 5'd6, 0, 1'b0, 32'd0, 32'd0, 5'd0);
    run_div(32'd1234, 32'd10, 5'd0, 0, 1'b0, 32'd0, 32'd0, 5'd0);
    run_div(32'd999, 32'd3, 5'd7, 2, 1'b0, 32'd0, 32'd0, 5'd0);
    run_div(32'd100, 32'd7, 5'd5, 0, 1'b1, 32'd81, -32'sd9, 5'd12);
    run_div(32'd81, -32'sd9, 5'd12, 0, 1'b0, 32'd0, 32'd0, 5'd0);

    // Start/flush together in IDLE must not issue.
    applyStimulus(1'b1, 1'b1, 32'd8, 32'd2, 5'd1);
    @(negedge clock);
    checkOutput("idle_flush_stall", 32'(stall), 32'd0);
    next_cycle();
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    @(negedge clock);
    checkOutput("idle_flush_div", 32'(div_ctrl_DIV), 32'd0);
    next_cycle();

    // Reset in the middle of WAIT clears everything without a clock edge.
    applyStimulus(1'b1, 1'b0, 32'd77, 32'd5, 5'd21);
    next_cycle();
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    next_cycle();
    #2;
    reset = 1'b1;
    #1;
    checkOutput("arst_opA", div_operandA, 32'd0);
    checkOutput("arst_opB", 32'(div_operandB), 32'd0);
    checkOutput("arst_wb_data", wb_data, 32'd0);
    checkOutput("arst_wb_reg", 32'(wb_reg), 32'd0);
    checkOutput("arst_wb_exc", 32'(wb_exception), 32'd0);
    checkOutput("arst_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("arst_div", 32'(div_ctrl_DIV), 32'd0);
    checkOutput("arst_stall", 32'(stall), 32'd0);
    next_cycle();
    reset   = 1'b0;
    chained = 1'b0;
    run_div(32'd100, 32'd7, 5'd5, 0, 1'b0, 32'd0, 32'd0, 5'd0);

    cur_a   = $urandom;
    cur_b   = rand_b();
    cur_tag = 5'($urandom);
    for (int i = 0; i < 60; i++) begin
      flush_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, L)) : 0;
      chain    = (flush_at == 0) && ($urandom_range(0, 1) == 1);
      nxt_a    = $urandom;
      nxt_b    = rand_b();
      nxt_tag  = 5'($urandom);
      run_div(cur_a, cur_b, cur_tag, flush_at, chain, nxt_a, nxt_b, nxt_tag);
      cur_a   = nxt_a;
      cur_b   = nxt_b;
      cur_tag = nxt_tag;
    end
    if (chained)
      run_div(cur_a, cur_b, cur_tag, 0, 1'b0, 32'd0, 32'd0, 5'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/div_issue_ctrl.md
DIV_ISSUE_CTRL -- requirements
Module: div_issue_ctrl

Interface
REQ-001 Parameter DIV_LATENCY, default 4, number of WAIT cycles the combinational divider is given to settle (legal range 1..15).
REQ-002 clock  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ctrl_start  input  1  divide instruction present in execute stage this cycle.
REQ-005 flush  input  1  squash the in-flight or presented divide.
REQ-006 op_a  input  32  signed dividend.
REQ-007 op_b  input  32  signed divisor.
REQ-008 dest_reg  input  5  destination register tag.
REQ-009 div_operandA  output  32  registered dividend to the divider.
REQ-010 div_operandB  output  16  registered op_b[15:0] to the divider.
REQ-011 div_ctrl_DIV  output  1  high while in WAIT.
REQ-012 div_result  input  32  divider quotient (combinational).
REQ-013 div_exception  input  1  divider divide-by-zero flag.
REQ-014 stall  output  1  freezes upstream pipeline stages.
REQ-015 wb_valid  output  1  one-cycle writeback strobe.
REQ-016 wb_data  output  32  registered quotient.
REQ-017 wb_reg  output  5  registered destination tag.
REQ-018 wb_exception  output  1  registered exception flag for the writeback.

Function
REQ-019 FSM states SHALL be IDLE, WAIT, DONE; 4-bit down-counter cnt.
REQ-020 IDLE: ctrl_start & ~flush SHALL capture op_a, op_b[15:0], dest_reg, and range flag, load cnt=DIV_LATENCY-1, go WAIT; otherwise stay IDLE.
REQ-021 Range flag SHALL be set when op_b[31:16] is not the sign extension of op_b[15].
REQ-022 WAIT: cnt!=0 SHALL decrement; cnt==0 SHALL register wb_data, wb_reg, wb_exception and go DONE.
REQ-023 wb_exception SHALL be div_exception | range flag; when set, wb_data SHALL be 32'h0.
REQ-024 DONE: wb_valid=1 for exactly that cycle; then IDLE, or, if ctrl_start & ~flush, capture and go WAIT directly (back-to-back).
REQ-025 stall SHALL be combinational: 1 in WAIT, and 1 in IDLE/DONE when ctrl_start & ~flush; else 0.
REQ-026 Latency: start seen in cycle 0 -> stall high cycles 0..DIV_LATENCY, wb_valid in cycle DIV_LATENCY+1.
REQ-027 ctrl_start during WAIT SHALL be ignored (pipeline is stalled).
REQ-028 flush in WAIT SHALL return to IDLE next edge with no wb_valid; flush has priority over a simultaneous ctrl_start.
REQ-029 flush in DONE SHALL NOT suppress the current wb_valid (instruction already complete).
REQ-030 Captured divider operands SHALL remain stable throughout WAIT.
REQ-031 dest_reg 0 SHALL pass through unchanged; the register file discards it.

Reset
REQ-032 reset SHALL force IDLE, cnt=0, and all registered outputs (div_operandA, div_operandB, wb_data, wb_reg, wb_exception, wb_valid) to 0 immediately, including mid-WAIT; stall SHALL then follow REQ-025.

Structure
REQ-033 State encoding and the DIV_LATENCY default SHALL live in the shared processor package.
REQ-034 No sub-module; the divider SHALL remain an external instance wired beside this block.

Verification
REQ-035 L=4, op_a=100, op_b=7, dest_reg=5 -> stall high cycles 0-4, wb_valid cycle 5, wb_data=14, wb_reg=5, wb_exception=0.
REQ-036 op_a=-100, op_b=7 -> wb_data=32'hFFFFFFF2.
REQ-037 op_b=0 -> wb_exception=1, wb_data=0; op_b=32'h00010000 -> wb_exception=1 via range flag.
REQ-038 flush asserted in WAIT cycle 2 -> IDLE at cycle 3, no wb_valid, stall low from cycle 3.
REQ-039 reset asserted mid-WAIT -> all outputs 0 asynchronously; a new start after release completes normally.
REQ-040 ctrl_start held in DONE -> wb_valid for the first divide and the second divide captured with no idle cycle; second wb_valid L+1 cycles later.
